// File: rtl/pipe_adder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipe_adder
//
// Pipelined add/subtract unit for the band-pass filter datapath. The WIDTH-bit
// carry chain is split into STAGES chunks of CW = WIDTH/STAGES bits; stage k
// adds chunk k and registers the chunk result together with its carry, the
// operands still to be consumed, the partial result and the sub flag.
//
// Arithmetic: b_eff = sub ? ~b : b, carry0 = sub ? ~c_in : c_in,
//             sum = a + b_eff + carry0 (mod 2^WIDTH), so sub gives a - b - c_in.
//
// Handshake: a beat moves on a clock edge when its valid is high and the
// receiver's ready is high. The whole pipe stalls together:
//   advance = !out_valid || out_ready, in_ready = advance.
// Bubbles are carried through, never squeezed out.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   unit accepts a beat this cycle
//   a, b       operands (WIDTH bits)
//   c_in       carry-in (add) / borrow-in (sub)
//   sub        0 = add, 1 = subtract
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        result (WIDTH bits)
//   c_out      raw carry out of the MSB (sub: 1 = no borrow)
//   overflow   signed two's-complement overflow
//
// Build option: define PIPE_ADDER_SAT_EN to saturate sum to the signed limit
// on overflow (limit picked by a[MSB]); c_out and overflow stay raw.
// -----------------------------------------------------------------------------
module pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam int MSB  = WIDTH - 1;
    // Inter-stage registers exist only between stages; keep at least one entry
    // so the declarations stay legal for STAGES == 1.
    localparam int PIPE = (STAGES > 1) ? STAGES - 1 : 1;

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be divisible by STAGES");
    end

    // Per-stage valid bits; the last one is out_valid.
    logic [STAGES-1:0] valid_q, valid_d;

    // Beat payload between stage k and stage k+1.
    logic [WIDTH-1:0]  a_q   [PIPE];
    logic [WIDTH-1:0]  a_d   [PIPE];
    logic [WIDTH-1:0]  b_q   [PIPE];
    logic [WIDTH-1:0]  b_d   [PIPE];
    logic [WIDTH-1:0]  res_q [PIPE];
    logic [WIDTH-1:0]  res_d [PIPE];
    logic [PIPE-1:0]   sub_q, sub_d;
    logic [PIPE-1:0]   carry_q, carry_d;

    // Output registers of the final stage.
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              c_out_q, c_out_d;
    logic              ovf_q, ovf_d;

    logic              advance;

    assign advance  = !valid_q[LAST] || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in, b_in, r_in, res_w;
        logic             c_st, s_in, v_in;
        logic [CW-1:0]    b_chunk;
        logic [CW:0]      chunk_sum;

        if (k == 0) begin : g_first
            assign a_in = a;
            assign b_in = b;
            assign c_st = sub ^ c_in;      // carry0 = sub ? ~c_in : c_in
            assign r_in = '0;
            assign s_in = sub;
            assign v_in = in_valid;
        end else begin : g_next
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign c_st = carry_q[k-1];
            assign r_in = res_q[k-1];
            assign s_in = sub_q[k-1];
            assign v_in = valid_q[k-1];
        end

        // b travels raw; each stage inverts only the chunk it consumes.
        assign b_chunk   = s_in ? ~b_in[k*CW +: CW] : b_in[k*CW +: CW];
        assign chunk_sum = {1'b0, a_in[k*CW +: CW]} + {1'b0, b_chunk}
                         + {{CW{1'b0}}, c_st};

        always_comb begin
            res_w              = r_in;
            res_w[k*CW +: CW]  = chunk_sum[CW-1:0];
        end

        assign valid_d[k] = v_in;

        if (k == LAST) begin : g_out
            logic ovf_w;
            // b_chunk[CW-1] is the MSB of b_eff in the top chunk.
            assign ovf_w   = (a_in[MSB] == b_chunk[CW-1]) && (res_w[MSB] != a_in[MSB]);
            assign ovf_d   = ovf_w;
            assign c_out_d = chunk_sum[CW];
`ifdef PIPE_ADDER_SAT_EN
            // Operands share a sign on overflow, so a[MSB] gives the true sign.
            assign sum_d = !ovf_w    ? res_w :
                           a_in[MSB] ? {1'b1, {MSB{1'b0}}} :
                                       {1'b0, {MSB{1'b1}}};
`else
            assign sum_d = res_w;
`endif
        end else begin : g_fwd
            assign a_d[k]     = a_in;
            assign b_d[k]     = b_in;
            assign res_d[k]   = res_w;
            assign sub_d[k]   = s_in;
            assign carry_d[k] = chunk_sum[CW];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            sub_q   <= '0;
            carry_q <= '0;
            for (int k = 0; k < LAST; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (advance) begin
            valid_q <= valid_d;
            for (int k = 0; k < LAST; k++) begin
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                res_q[k]   <= res_d[k];
                sub_q[k]   <= sub_d[k];
                carry_q[k] <= carry_d[k];
            end
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;

endmodule
